// File: rtl/piso_pkg.sv
// Shared constants and types for the PISO shift transmitter.
//   NIBBLE_W   : width of one transmitted word
//   FIFO_DEPTH : number of nibbles the input buffer can hold
//   state_e    : transmitter FSM states
package piso_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = $clog2(NIBBLE_W);
  localparam int unsigned FCNT_W     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/nibble_fifo.sv
// Two-entry nibble FIFO with synchronous active-high reset.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous reset, empties the FIFO
//   push_i  : write data_i this edge (ignored when full)
//   data_i  : nibble to write
//   pop_i   : discard head this edge (ignored when empty)
//   head_o  : oldest buffered nibble
//   count_o : number of buffered nibbles (0..FIFO_DEPTH)
module nibble_fifo
  import piso_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [NIBBLE_W-1:0] data_i,
  input  logic                pop_i,
  output logic [NIBBLE_W-1:0] head_o,
  output logic [FCNT_W-1:0]   count_o
);

  logic [NIBBLE_W-1:0] mem_q [FIFO_DEPTH];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [FCNT_W-1:0]   count_q;
  logic                do_push;
  logic                do_pop;

  assign do_push = push_i && (count_q < FCNT_W'(FIFO_DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/piso_shift_transmitter.sv
// Parallel-in serial-out nibble transmitter, MSB first, with a 2-entry input FIFO.
//   sck        : clock, rising edge
//   rst        : synchronous active-high reset
//   din        : nibble to transmit, bit 3 first
//   din_valid  : din offered this cycle
//   din_ready  : din accepted this cycle (FIFO not full)
//   ready      : shift enable
//   done       : halt, overrides ready
//   mosi       : serial bit currently presented
//   mosi_valid : mosi is consumed at the next rising edge
//   pulse      : last bit of a nibble consumed this cycle
//   busy       : shifter holds a nibble
//   fifo_count : buffered nibbles (0..2)
module piso_shift_transmitter
  import piso_pkg::*;
(
  input  logic                sck,
  input  logic                rst,
  input  logic [NIBBLE_W-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic                ready,
  input  logic                done,
  output logic                mosi,
  output logic                mosi_valid,
  output logic                pulse,
  output logic                busy,
  output logic [FCNT_W-1:0]   fifo_count
);

  state_e              state_q, state_d;
  logic [NIBBLE_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                advance;
  logic                push;
  logic                pop;
  logic [NIBBLE_W-1:0] head;
  logic                fifo_nonempty;
  logic                last_bit;

  assign advance       = ready && !done;
  // Full means not ready even if the shifter pops this same cycle.
  assign din_ready     = fifo_count < FCNT_W'(FIFO_DEPTH);
  assign push          = din_valid && din_ready;
  assign fifo_nonempty = fifo_count != '0;
  assign last_bit      = bit_cnt_q == CNT_W'(NIBBLE_W - 1);

  nibble_fifo u_fifo (
    .clk_i   (sck),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (din),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          shift_d   = head;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (advance) begin
          shift_d   = {shift_q[NIBBLE_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit) begin
            // Reload straight from the FIFO so consecutive nibbles have no gap bit.
            if (fifo_nonempty) begin
              pop       = 1'b1;
              shift_d   = head;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign busy       = state_q == SHIFT;
  assign mosi       = busy && shift_q[NIBBLE_W-1];
  assign mosi_valid = busy && advance;
  assign pulse      = busy && advance && last_bit;

endmodule

// File: tb/tb_piso_shift_transmitter.sv
module tb_piso_shift_transmitter;

  logic       sck;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       ready;
  logic       done;
  logic       mosi;
  logic       mosi_valid;
  logic       pulse;
  logic       busy;
  logic [1:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  piso_shift_transmitter dut (
    .sck        (sck),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ready      (ready),
    .done       (done),
    .mosi       (mosi),
    .mosi_valid (mosi_valid),
    .pulse      (pulse),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  // Receiver model for the loopback run: MSB-first shift of consumed bits.
  logic       rx_en = 1'b0;
  logic [3:0] rx_sr = 4'h0;
  int         rx_bits = 0;
  int         tx_pulses = 0;
  logic [3:0] rx_q[$];

  always @(posedge sck) begin
    if (rst) begin
      rx_bits = 0;
    end else if (rx_en) begin
      if (pulse) tx_pulses++;
      if (mosi_valid) begin
        rx_sr = {rx_sr[2:0], mosi};
        rx_bits++;
        if (rx_bits == 4) begin
          rx_q.push_back(rx_sr);
          rx_bits = 0;
        end
      end
    end
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle a little after it.
  task automatic step();
    @(posedge sck);
    #2;
  endtask

  logic [3:0]  exp4;
  logic [7:0]  exp8;
  logic [11:0] exp12;
  logic [3:0]  cand;
  logic [3:0]  tx_q[$];
  logic        acc;
  int          sent;
  int          cyc;

  initial begin
    rst = 1'b1; din = 4'h0; din_valid = 1'b0; ready = 1'b1; done = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk_bit("rst_mosi", mosi, 1'b0);
    chk_bit("rst_mosi_valid", mosi_valid, 1'b0);
    chk_bit("rst_pulse", pulse, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_val("rst_fifo_count", int'(fifo_count), 0);
    chk_bit("rst_din_ready", din_ready, 1'b1);

    // Single nibble 1011: loaded one edge after push, then 4 bits.
    din = 4'hB; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    #1;
    chk_val("t1_count_after_push", int'(fifo_count), 1);
    chk_bit("t1_idle_valid", mosi_valid, 1'b0);
    step();
    chk_bit("t1_busy", busy, 1'b1);
    exp4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk_bit("t1_mosi", mosi, exp4[3-i]);
      chk_bit("t1_valid", mosi_valid, 1'b1);
      chk_bit("t1_pulse", pulse, i == 3);
      step();
    end
    chk_bit("t1_busy_end", busy, 1'b0);
    chk_bit("t1_valid_end", mosi_valid, 1'b0);
    chk_bit("t1_mosi_end", mosi, 1'b0);

    // A then 5 back to back; push/pop on the same edge keeps count at 1.
    din = 4'hA; din_valid = 1'b1;
    step();
    din = 4'h5;
    step();
    din_valid = 1'b0;
    #1;
    chk_val("t2_count_pushpop", int'(fifo_count), 1);
    exp8 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk_bit("t2_mosi", mosi, exp8[7-i]);
      chk_bit("t2_valid", mosi_valid, 1'b1);
      chk_bit("t2_pulse", pulse, (i == 3) || (i == 7));
      step();
    end
    chk_bit("t2_busy_end", busy, 1'b0);

    // C with a 3-cycle halt after the second bit.
    din = 4'hC; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    chk_bit("t3_bit0", mosi, 1'b1);
    step();
    chk_bit("t3_bit1", mosi, 1'b1);
    step();
    done = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_bit("t3_hold_mosi", mosi, 1'b0);
      chk_bit("t3_hold_valid", mosi_valid, 1'b0);
      chk_bit("t3_hold_busy", busy, 1'b1);
      chk_bit("t3_hold_pulse", pulse, 1'b0);
      step();
    end
    done = 1'b0;
    #1;
    chk_bit("t3_bit2", mosi, 1'b0);
    chk_bit("t3_bit2_valid", mosi_valid, 1'b1);
    chk_bit("t3_bit2_pulse", pulse, 1'b0);
    step();
    chk_bit("t3_bit3", mosi, 1'b0);
    chk_bit("t3_bit3_pulse", pulse, 1'b1);
    step();
    chk_bit("t3_busy_end", busy, 1'b0);

    // Fill while stalled; a push while full must be dropped.
    ready = 1'b0;
    din = 4'h1; din_valid = 1'b1;
    step();
    din = 4'h2;
    step();
    #1;
    chk_val("t4_count_load", int'(fifo_count), 1);
    chk_bit("t4_busy", busy, 1'b1);
    chk_bit("t4_stall_valid", mosi_valid, 1'b0);
    din = 4'h3;
    step();
    chk_val("t4_count_full", int'(fifo_count), 2);
    chk_bit("t4_din_ready_low", din_ready, 1'b0);
    din = 4'hF;
    step();
    chk_val("t4_count_ignored", int'(fifo_count), 2);
    step();
    chk_bit("t4_din_ready_still_low", din_ready, 1'b0);
    din_valid = 1'b0; ready = 1'b1;
    #1;
    exp12 = 12'h123;
    for (int i = 0; i < 12; i++) begin
      chk_bit("t4_mosi", mosi, exp12[11-i]);
      chk_bit("t4_valid", mosi_valid, 1'b1);
      chk_bit("t4_pulse", pulse, (i == 3) || (i == 7) || (i == 11));
      if (i == 4) begin
        chk_val("t4_count_after_pop", int'(fifo_count), 1);
        chk_bit("t4_din_ready_back", din_ready, 1'b1);
      end
      step();
    end
    chk_bit("t4_busy_end", busy, 1'b0);
    chk_val("t4_count_end", int'(fifo_count), 0);

    // Reset after two bits of 9 with 3 buffered.
    din = 4'h9; din_valid = 1'b1;
    step();
    din = 4'h3;
    step();
    din_valid = 1'b0;
    #1;
    chk_bit("t5_bit0", mosi, 1'b1);
    chk_val("t5_count", int'(fifo_count), 1);
    step();
    chk_bit("t5_bit1", mosi, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk_bit("t5_rst_valid", mosi_valid, 1'b0);
    chk_val("t5_rst_count", int'(fifo_count), 0);
    chk_bit("t5_rst_busy", busy, 1'b0);
    chk_bit("t5_rst_mosi", mosi, 1'b0);
    chk_bit("t5_rst_din_ready", din_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk_bit("t5_no_pulse", pulse, 1'b0);
      chk_bit("t5_idle", busy, 1'b0);
      step();
    end
    din = 4'h6; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    exp4 = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      chk_bit("t5_mosi", mosi, exp4[3-i]);
      chk_bit("t5_pulse", pulse, i == 3);
      step();
    end
    chk_bit("t5_busy_end", busy, 1'b0);

    // Loopback with random stalls and 16 random nibbles.
    rx_en = 1'b1;
    sent = 0;
    cyc = 0;
    cand = 4'($urandom);
    while ((sent < 16 || rx_q.size() < 16) && cyc < 3000) begin
      ready = ($urandom_range(0, 3) != 0);
      done  = ($urandom_range(0, 7) == 0);
      if (sent < 16) begin
        din = cand;
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      #1;
      acc = din_valid && din_ready;
      step();
      if (acc) begin
        tx_q.push_back(cand);
        sent++;
        cand = 4'($urandom);
      end
      cyc++;
    end
    din_valid = 1'b0; ready = 1'b1; done = 1'b0;
    step();
    chk_bit("t6_no_timeout", cyc < 3000, 1'b1);
    chk_val("t6_rx_count", rx_q.size(), 16);
    chk_val("t6_tx_pulses", tx_pulses, rx_q.size());
    for (int i = 0; i < rx_q.size() && i < tx_q.size(); i++) begin
      chk_val("t6_nibble", int'(rx_q[i]), int'(tx_q[i]));
    end
    chk_bit("t6_busy_end", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_shift_transmitter.md
PISO_SHIFT_TRANSMITTER -- requirements
Module: piso_shift_transmitter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named as follows.
REQ-002 sck  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 din  in  4  parallel nibble to transmit; bit 3 is sent first.
REQ-005 din_valid  in  1  din is offered this cycle.
REQ-006 din_ready  out  1  block accepts din this cycle.
REQ-007 ready  in  1  shift enable, same meaning as the receiver's ready.
REQ-008 done  in  1  halt; while high, no bit advances.
REQ-009 mosi  out  1  serial data bit currently presented.
REQ-010 mosi_valid  out  1  mosi is consumed at the next rising edge.
REQ-011 pulse  out  1  high in the cycle the 4th (LSB) bit of a nibble is consumed.
REQ-012 busy  out  1  shifter holds a nibble (state SHIFT).
REQ-013 fifo_count  out  2  number of nibbles buffered (0..2).

Function
REQ-014 advance SHALL be defined as ready && !done.
REQ-015 A 2-entry FIFO SHALL buffer nibbles; a push occurs on an edge where din_valid && din_ready.
REQ-016 din_ready SHALL be (fifo_count < 2), independent of a same-cycle pop; there is no pass-through when full.
REQ-017 The FSM SHALL have two states: IDLE and SHIFT.
REQ-018 In IDLE with fifo_count > 0, the next edge SHALL pop the head into shift_reg, clear bit_cnt, and enter SHIFT, regardless of advance.
REQ-019 In SHIFT, mosi SHALL equal shift_reg[3] combinationally, and mosi_valid SHALL equal advance.
REQ-020 In IDLE, mosi and mosi_valid SHALL be 0.
REQ-021 On an edge in SHIFT with advance, shift_reg SHALL shift left by one (zero fill) and bit_cnt SHALL increment modulo 4.
REQ-022 Without advance, shift_reg, bit_cnt, mosi and the FSM SHALL hold.
REQ-023 pulse SHALL equal (state==SHIFT) && advance && (bit_cnt==3).
REQ-024 On a pulse edge with fifo_count > 0 (count before any same-edge push), the next nibble SHALL load and the FSM stays in SHIFT (back-to-back, no gap bit); otherwise the FSM SHALL go to IDLE.
REQ-025 A nibble pushed into an empty FIFO during IDLE SHALL present its first bit exactly 2 cycles after the accepting edge.
REQ-026 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-027 A push while din_ready is low SHALL be ignored; din is not captured.
REQ-028 With mosi connected and shared sck/ready/done, the paired receiver SHALL output the transmitted nibble unchanged.

Reset
REQ-029 While rst is high at an edge, the block SHALL set state=IDLE, bit_cnt=0, shift_reg=0, and empty the FIFO.
REQ-030 Reset values SHALL be: mosi=0, mosi_valid=0, pulse=0, busy=0, fifo_count=0, din_ready=1 (the cycle after reset).
REQ-031 Reset mid-nibble SHALL discard the partial nibble and all buffered nibbles without producing a pulse.
REQ-032 rst SHALL take priority over push, pop and advance.

Structure
REQ-033 Package piso_pkg SHALL hold NIBBLE_W=4, FIFO_DEPTH=2, and the state enum (IDLE, SHIFT).
REQ-034 The FIFO SHALL be a sub-module named nibble_fifo (push/pop/count/head); the FSM and shifter stay in the top module.

Verification
REQ-035 Reset, then push 4'b1011 with ready=1, done=0 -> mosi 1,0,1,1 on 4 consecutive cycles starting 2 cycles after the push; pulse on the 4th; busy low afterward.
REQ-036 Push 4'hA then 4'h5 back-to-back, ready=1 -> 8 consecutive valid bits 1010_0101; pulse at bits 4 and 8; no gap.
REQ-037 Push 4'hC, then hold done=1 for 3 cycles after the 2nd bit -> mosi holds 0 and mosi_valid is 0 for 3 cycles; sequence resumes as 1,1,0,0.
REQ-038 Push 3 nibbles with ready=0 -> fifo_count reaches 2 after the shifter loads; din_ready goes low; the 3rd push is accepted only after the first pop.
REQ-039 Assert rst after 2 bits of 4'h9 with 4'h3 buffered -> next cycle mosi_valid=0, fifo_count=0, pulse never seen; a new push of 4'h6 sends 0,1,1,0.
REQ-040 Loopback to the receiver with 16 random nibbles -> receiver parallel_out matches each nibble in order, with one receiver pulse per transmitter pulse.
